// File: rtl/scan_ctrl.sv
// Bit-scan control FSM for the 8-bit y / 3-bit s datapath.
// Outputs are registered and decoded from the next state, so they depend on the current state only.
module scan_ctrl #(
    parameter logic [1:0] STEP     = 2'd1,
    parameter logic [3:0] MAX_ITER = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       b,
    input  logic       flag,
    output logic [1:0] y_select_next,
    output logic [1:0] s_step,
    output logic       y_en,
    output logic       s_en,
    output logic       y_store_x,
    output logic       s_add,
    output logic       s_zero,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_STEP,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [1:0] r_mode;
    logic [3:0] w_cnt_inc;
    logic       w_wdog;

    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_wdog    = (w_cnt_inc == MAX_ITER);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_TEST;
            S_TEST:  w_next = b ? S_ADD : S_STEP;
            S_ADD:   w_next = S_STEP;
            S_STEP:  w_next = (flag || w_wdog) ? S_DONE : S_TEST;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_mode        <= 2'd0;
            timeout       <= 1'b0;
            y_select_next <= 2'd0;
            s_step        <= 2'd0;
            y_en          <= 1'b0;
            s_en          <= 1'b0;
            y_store_x     <= 1'b0;
            s_add         <= 1'b0;
            s_zero        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_LOAD) begin
                r_mode  <= mode;
                r_cnt   <= 4'd0;
                timeout <= 1'b0;
            end

            // Watchdog only fires when the flag did not end the scan first.
            if (r_state == S_STEP) begin
                if (r_cnt != 4'hF)
                    r_cnt <= w_cnt_inc;
                if (!flag && w_wdog)
                    timeout <= 1'b1;
            end

            y_select_next <= 2'd0;
            s_step        <= 2'd0;
            y_en          <= 1'b0;
            s_en          <= 1'b0;
            y_store_x     <= 1'b0;
            s_add         <= 1'b0;
            s_zero        <= 1'b0;
            busy          <= (w_next != S_IDLE);
            done          <= 1'b0;

            unique case (w_next)
                S_LOAD: begin
                    y_store_x <= 1'b1;
                    y_en      <= 1'b1;
                    s_en      <= 1'b1;
                    s_zero    <= 1'b1;
                    s_add     <= 1'b1;
                end
                S_ADD: begin
                    y_en          <= 1'b1;
                    y_select_next <= r_mode[0] ? 2'd3 : 2'd2;
                end
                S_STEP: begin
                    s_en   <= 1'b1;
                    s_step <= STEP;
                    s_add  <= ~r_mode[1];
                end
                S_DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with a behavioural y/s datapath around it.
// A second instance with STEP=2 exercises the watchdog path.
module tb_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [1:0] mode, mode2;
    logic [7:0] x;

    logic       b, flag, b2, flag2;
    logic [1:0] ysel, sstep, ysel2, sstep2;
    logic       y_en, s_en, ysx, s_add, s_zero, busy, done, timeout;
    logic       y_en2, s_en2, ysx2, s_add2, s_zero2, busy2, done2, timeout2;

    logic [7:0] y, y2;
    logic [2:0] s, s2;
    logic [2:0] s_nx, s_nx2;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_done2 = 0;

    always #5 clk = ~clk;

    scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .b(b), .flag(flag),
        .y_select_next(ysel), .s_step(sstep),
        .y_en(y_en), .s_en(s_en), .y_store_x(ysx),
        .s_add(s_add), .s_zero(s_zero),
        .busy(busy), .done(done), .timeout(timeout)
    );

    scan_ctrl #(.STEP(2'd2), .MAX_ITER(4'd8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2),
        .b(b2), .flag(flag2),
        .y_select_next(ysel2), .s_step(sstep2),
        .y_en(y_en2), .s_en(s_en2), .y_store_x(ysx2),
        .s_add(s_add2), .s_zero(s_zero2),
        .busy(busy2), .done(done2), .timeout(timeout2)
    );

    // datapath models
    always_comb begin
        s_nx  = s_add ? ((s_zero ? 3'd0 : s) + {1'b0, sstep})
                      : ((s_zero ? 3'd0 : s) - {1'b0, sstep});
        s_nx2 = s_add2 ? ((s_zero2 ? 3'd0 : s2) + {1'b0, sstep2})
                       : ((s_zero2 ? 3'd0 : s2) - {1'b0, sstep2});
    end
    assign flag  = (s_nx == 3'd3);
    assign flag2 = (s_nx2 == 3'd3);
    assign b     = y[s];
    assign b2    = y2[s2];

    always @(posedge clk) begin
        if (y_en)
            y <= ysx ? x : (ysel == 2'd2) ? y + {5'd0, s}
                         : (ysel == 2'd3) ? y - {5'd0, s} : y;
        if (s_en) s <= s_nx;
        if (y_en2)
            y2 <= ysx2 ? x : (ysel2 == 2'd2) ? y2 + {5'd0, s2}
                           : (ysel2 == 2'd3) ? y2 - {5'd0, s2} : y2;
        if (s_en2) s2 <= s_nx2;
    end

    always @(negedge clk) begin
        if (done)  n_done++;
        if (done2) n_done2++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [1:0] m, input logic [7:0] xv,
                           output int cyc);
        mode  = m;
        x     = xv;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        if (cyc >= 40) chk("job_bound", 32'(cyc), 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;
        logic [7:0] yh;
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        mode2  = 2'd0;
        x      = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_yen", y_en, 1'b0);
        chk("rst_sen", s_en, 1'b0);
        chk("rst_ysel", ysel, 2'd0);
        chk("rst_tmo", timeout, 1'b0);
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);

        // ascending add, and LOAD-cycle outputs
        mode  = 2'd0;
        x     = 8'h06;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ysx", {ysx, y_en, s_en, s_zero, s_add, busy}, 6'b111111);
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("add_lat", 32'(cyc), 32'd10);
        chk("add_y", y, 8'h09);
        chk("add_s", s, 3'd3);
        chk("add_tmo", timeout, 1'b0);
        tick();
        chk("add_ndone", 32'(n_done), 32'd1);
        chk("add_idle", busy, 1'b0);

        run_job(2'd1, 8'h07, cyc);
        chk("sub_lat", 32'(cyc), 32'd11);
        chk("sub_y", y, 8'h04);
        chk("sub_s", s, 3'd3);
        tick();

        run_job(2'd2, 8'hF0, cyc);
        chk("dsc_lat", 32'(cyc), 32'd15);
        chk("dsc_y", y, 8'h02);
        chk("dsc_s", s, 3'd3);
        chk("dsc_tmo", timeout, 1'b0);
        tick();

        // watchdog on the STEP=2 instance
        mode2  = 2'd0;
        x      = 8'h00;
        d0     = n_done2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc    = 1;
        while (!done2 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("wd_lat", 32'(cyc), 32'd18);
        chk("wd_tmo", timeout2, 1'b1);
        chk("wd_done", done2, 1'b1);
        chk("wd_s", s2, 3'd0);
        tick();
        chk("wd_sticky", timeout2, 1'b1);
        chk("wd_ndone", 32'(n_done2 - d0), 32'd1);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        chk("wd_clear", timeout2, 1'b0);
        for (int i = 0; i < 20 && busy2; i++) tick();
        chk("wd_end", busy2, 1'b0);

        // reset during ADD
        mode  = 2'd0;
        x     = 8'h06;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!(y_en && !ysx) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("mid_add", {y_en, ysx, ysel}, 4'b1010);
        rst = 1'b0;
        tick();
        chk("mid_busy", busy, 1'b0);
        chk("mid_en", {y_en, s_en}, 2'b00);
        yh = y;
        tick();
        chk("mid_hold", y, yh);
        rst = 1'b1;
        tick();
        run_job(2'd0, 8'h06, cyc);
        chk("post_lat", 32'(cyc), 32'd10);
        chk("post_y", y, 8'h09);
        tick();

        // start held high across a job
        d0    = n_done;
        mode  = 2'd0;
        x     = 8'h06;
        start = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("hold_idle", busy, 1'b0);
        chk("hold_n1", 32'(n_done - d0), 32'd1);
        tick();
        chk("hold_relo", {busy, ysx}, 2'b11);
        start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("hold_y", y, 8'h09);
        chk("hold_n2", 32'(n_done - d0), 32'd2);

        // start pulse in TEST is ignored
        d0    = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        tick();
        tick();
        chk("test_ign_n", 32'(n_done - d0), 32'd1);
        chk("test_ign_b", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Control unit (FSM) for the 8-bit y / 3-bit s bit-scan datapath.
- Drives the datapath control inputs: y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero.
- Consumes the datapath status signals: b (= y[s]) and flag (= next s equals 3).
- Runs one scan job per start pulse: load x, walk s, conditionally add/subtract s to y at each set bit, stop on flag or watchdog.

Parameters:
- STEP, 2'd1, value driven on s_step during STEP state (stride of s).
- MAX_ITER, 4'd8, watchdog: max STEP states per job before forced abort.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  job request; sampled only in IDLE.
- mode  input  2  mode[0]: 0 = y+s, 1 = y−s on set bit; mode[1]: 0 = s ascends, 1 = s descends. Latched in LOAD.
- b  input  1  datapath selected bit y[s].
- flag  input  1  datapath: s_in == 3 (combinational from control outputs).
- y_select_next  output  2  0 = hold, 2 = y+s, 3 = y−s (1 unused).
- s_step  output  2  step applied to s.
- y_en, s_en  output  1 each  register enables.
- y_store_x  output  1  load x into y.
- s_add  output  1  1 = s_base + s_step, 0 = s_base − s_step.
- s_zero  output  1  s_base = 0.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- timeout  output  1  sticky per job: set on watchdog abort, cleared at next LOAD.

Behaviour:
- All control outputs are Moore, decoded from the state register only. No combinational path from flag or b to any output; flag depends on these outputs, so such a path would form a loop.
- Reset: on a clk edge with rst=0:
  - state=IDLE, iteration counter=0, latched mode=0, timeout=0.
  - All enables 0, y_select_next=0, s_step=0, s_add=0, s_zero=0, busy=0, done=0.
  - Reset mid-job aborts with no further datapath writes. Datapath register contents are not restored by this block.
- IDLE:
  - All enables 0.
  - start=1 → LOAD. start while busy is ignored; no queuing.
- LOAD (1 cycle):
  - Outputs: y_store_x=1, y_en=1, s_en=1, s_zero=1, s_add=1, s_step=0. Result: y←x, s←0.
  - Latch mode, clear counter and timeout.
  - → TEST.
- TEST (1 cycle):
  - All enables 0; y and s stable so b is valid.
  - b=1 → ADD; b=0 → STEP.
- ADD (1 cycle):
  - Outputs: y_en=1, y_store_x=0, y_select_next = mode[0] ? 3 : 2.
  - → STEP.
- STEP (1 cycle):
  - Outputs: s_en=1, s_zero=0, s_step=STEP, s_add=~mode[1].
  - Counter increments (4-bit, saturating).
  - flag=1 → DONE. s lands on 3; bit 3 is not processed.
  - Else if counter+1 == MAX_ITER → DONE with timeout←1.
  - Else → TEST.
  - If flag and the watchdog limit coincide: DONE with timeout=0 (flag wins).
- DONE (1 cycle):
  - done=1, all enables 0.
  - → IDLE. start in DONE is ignored.
- Arithmetic wraps modulo datapath widths: y 8 bits, s 3 bits.
  - Descending from 0 visits 7, 6, 5, 4, then 3 (flag).
- Job latency in cycles = 1 (LOAD) + Σ per visited s (TEST + STEP, + ADD if b=1) + 1 (DONE).

Test Plan:
- Ascending add: mode=0, x=8'h06, start → states LOAD, TEST, STEP, TEST, ADD, STEP, TEST, ADD, STEP, DONE (10 cycles). Final y=8'h09, s=3; done pulses once; timeout=0.
- Ascending subtract: mode=1, x=8'h07 → bit0: y=7−0=7; bit1: y=7−1=6; bit2 (y[2]=1): y=6−2=4. Final y=8'h04, s=3.
- Descending: mode=2, x=8'hF0 → s visits 0, 7, 6, 5, 4.
  - bit7: y=F0+7=F7.
  - bit6: y[6]=1, y=F7+6=FD.
  - bit5: y[5]=1, y=FD+5=02 (wrap).
  - bit4: y[4]=0, no change.
  - Stop at s=3. Final y=8'h02.
- Watchdog: STEP=2, mode=0, x=0 → s visits 0, 2, 4, 6, 0, …; flag never asserts. After 8 STEP states: DONE with timeout=1, done=1.
- Reset mid-job: assert rst=0 during ADD → next edge IDLE, y_en=s_en=0, busy=0. Release, start again → normal job completes.
- Start handling:
  - start held high across the whole job → exactly one job runs, then a new job starts from IDLE.
  - start pulse during TEST → ignored; done count stays 1.
